// File: rtl/mac_pkg.sv
// Shared types and defaults for the mac_accum slice.
//   state_t   : controller states IDLE / ACC / DONE (binary encoded)
//   *_DEF     : default parameter values for PW, AW, LEN_W
//   full_add  : one-bit full-adder cell, returns {carry, sum}
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned PW_DEF    = 16;
  localparam int unsigned AW_DEF    = 24;
  localparam int unsigned LEN_W_DEF = 8;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/mac_acc_add.sv
// AW-bit ripple-carry adder built from the full-adder cell.
// Ports:
//   a_i    [AW-1:0]  accumulator operand
//   b_i    [AW-1:0]  zero-extended product operand
//   sum_o  [AW-1:0]  a_i + b_i modulo 2^AW
//   cout_o           carry out of bit AW-1
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic [AW-1:0] sum_o,
  output logic          cout_o
);

  always_comb begin
    logic carry;
    logic [1:0] fa;
    carry = 1'b0;
    sum_o = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      fa       = full_add(a_i[i], b_i[i], carry);
      sum_o[i] = fa[0];
      carry    = fa[1];
    end
    cout_o = carry;
  end

endmodule

// File: rtl/mac_accum.sv
// Streaming accumulator behind the 8x8 array multiplier: sums a burst of
// `len` unsigned products and presents the result over valid/ready.
// Build option: define MAC_SAT_EN to saturate the accumulator to all-ones
// on carry out instead of wrapping (out_ovf is set in both builds).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, len          begin a burst of len products (sampled in IDLE only)
//   in_valid/in_ready   product handshake, in_prod [PW-1:0]
//   out_valid/out_ready result handshake, out_sum [AW-1:0], out_ovf (sticky)
//   busy                high in ACC or DONE
// AW must be >= PW.
module mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned PW    = PW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    addend;
  logic [AW-1:0]    add_sum;
  logic             add_cout;
  logic             beat;

  assign addend = AW'(in_prod);
  assign beat   = in_valid && (state_q == ACC);

  mac_acc_add #(.AW(AW)) u_add (
    .a_i    (acc_q),
    .b_i    (addend),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len == '0) ? DONE : ACC;
      ACC:  if (beat && (cnt_q == LEN_W'(1))) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    busy      = (state_q == ACC) || (state_q == DONE);
    out_sum   = acc_q;
    out_ovf   = ovf_q;
  end

  // Datapath next state: load on start, accumulate on beat, otherwise hold
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if ((state_q == IDLE) && start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = len;
    end else if (beat) begin
`ifdef MAC_SAT_EN
      // Once all-ones, any nonzero addend carries again, so it stays pinned.
      acc_d = add_cout ? '1 : add_sum;
`else
      acc_d = add_sum;
`endif
      ovf_d = ovf_q | add_cout;
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
module tb_mac_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [23:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [15:0] b_out_sum;

  always #5 clk = ~clk;

  // 24-bit default build and a 16-bit build that can actually overflow
  mac_accum #(.PW(16), .AW(24), .LEN_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .busy(a_busy)
  );

  mac_accum #(.PW(16), .AW(16), .LEN_W(8)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  typedef struct {
    logic [23:0] s24;
    logic        o24;
    logic [15:0] s16;
    logic        o16;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] prods[$];
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, {31'd0, a_in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, a_out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
    chk({tag, "_busy16"}, {31'd0, b_busy}, 32'd0);
  endtask

  // Runs one burst over prods: gap idle cycles before each beat, hold cycles
  // of out_ready low in DONE, poke drives start during DONE (must be ignored).
  task automatic run_burst(input string tag, input int unsigned gap,
                           input int unsigned hold, input bit poke);
    logic [31:0] total;
    exp_t        e;
    exp_t        got;
    total = '0;
    chk_idle({tag, "_pre"});
    start = 1'b1;
    len   = 8'(prods.size());
    @(negedge clk);
    start = 1'b0;
    len   = 8'hAA;
    for (int k = 0; k < prods.size(); k++) begin
      for (int unsigned g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        chk({tag, "_gap_in_ready"}, {31'd0, a_in_ready}, 32'd1);
        chk({tag, "_gap_out_valid"}, {31'd0, a_out_valid}, 32'd0);
        @(negedge clk);
      end
      chk({tag, "_beat_in_ready"}, {31'd0, a_in_ready}, 32'd1);
      in_valid = 1'b1;
      in_prod  = prods[k];
      total    = total + {16'd0, prods[k]};
      @(negedge clk);
      in_valid = 1'b0;
      in_prod  = 16'hDEAD;
    end
    e.s24 = total[23:0];
    e.o24 = (total > 32'h00FF_FFFF);
    e.o16 = (total > 32'h0000_FFFF);
`ifdef MAC_SAT_EN
    e.s16 = e.o16 ? 16'hFFFF : total[15:0];
`else
    e.s16 = total[15:0];
`endif
    sb.push_back(e);
    // one cycle after the last beat (or after start for len 0)
    chk({tag, "_latency_out_valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, "_done_in_ready"}, {31'd0, a_in_ready}, 32'd0);
    out_ready = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        start = 1'b1;
        len   = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_hold_out_valid"}, {31'd0, a_out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'd0, a_in_ready}, 32'd0);
      chk({tag, "_hold_sum"}, {8'd0, a_out_sum}, {8'd0, e.s24});
    end
    out_ready = 1'b1;
    if (poke) start = 1'b1;
    chk({tag, "_hs_out_valid"}, {31'd0, a_out_valid}, 32'd1);
    if (a_out_valid && out_ready) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL %s_sb: observed empty expected entry", tag);
      end
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk({tag, "_sum24"}, {8'd0, a_out_sum}, {8'd0, got.s24});
        chk({tag, "_ovf24"}, {31'd0, a_out_ovf}, {31'd0, got.o24});
        chk({tag, "_sum16"}, {16'd0, b_out_sum}, {16'd0, got.s16});
        chk({tag, "_ovf16"}, {31'd0, b_out_ovf}, {31'd0, got.o16});
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk_idle({tag, "_post"});
  endtask

  initial begin
    #1;
    chk("rst_sum", {8'd0, a_out_sum}, 32'd0);
    chk("rst_ovf", {31'd0, a_out_ovf}, 32'd0);
    chk_idle("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // basic burst
    prods = '{16'h0001, 16'h00FF, 16'hFE01};
    run_burst("basic", 0, 0, 1'b0);

    // zero-length burst
    prods = '{};
    run_burst("zero", 0, 0, 1'b0);

    // gaps of 3 cycles, then backpressure with an ignored start in DONE
    prods = '{16'h1234, 16'h4321};
    run_burst("gaps", 3, 5, 1'b1);

    // carries out of the 16-bit build
    prods = '{16'hFFFF, 16'h0002};
    run_burst("ovf", 0, 0, 1'b0);
    prods = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0003};
    run_burst("ovf_long", 1, 2, 1'b0);

    // reset mid-burst after two of four beats
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_prod  = 16'h0007;
    @(negedge clk);
    in_prod  = 16'h0009;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy_before_rst", {31'd0, a_busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("mid_rst_sum", {8'd0, a_out_sum}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    prods = '{16'h0005};
    run_burst("after_rst", 0, 0, 1'b0);

    // back-to-back bursts, second must not include the first
    prods = '{16'h8000, 16'h8000, 16'h8000};
    run_burst("b2b_a", 0, 0, 1'b0);
    prods = '{16'h0011, 16'h0022};
    run_burst("b2b_b", 0, 0, 1'b0);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
